// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, one-entry code buffer.
// Define KEYPAD_REPEAT_EN to reissue the held key every REPEAT_CYCLES cycles.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun
);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [23:0] DEB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_rows_meta;
  logic [3:0]  r_rows_s;
  logic [1:0]  r_col;
  logic [1:0]  r_row;
  logic [3:0]  r_cols;
  logic [15:0] r_div_cnt;
  logic [23:0] r_deb_cnt;
  logic [3:0]  r_key_code;
  logic        r_key_valid;
  logic        r_overrun;

  logic [1:0]  w_low_row;
  logic [1:0]  w_next_col;
  logic        w_any_low;
  logic        w_row_low;
  logic        w_deb_done;
  logic        w_rep_fire;
  logic        w_issue;
  logic        w_consume;

  // Lowest-index low row wins when several rows of the column are pressed.
  always_comb begin
    w_low_row = 2'd3;
    if (!r_rows_s[2]) w_low_row = 2'd2;
    if (!r_rows_s[1]) w_low_row = 2'd1;
    if (!r_rows_s[0]) w_low_row = 2'd0;
  end

  assign w_any_low  = (r_rows_s != 4'hF);
  assign w_next_col = r_col + 2'd1;
  assign w_row_low  = ~r_rows_s[r_row];
  assign w_deb_done = (r_deb_cnt == DEB_LAST);
  assign w_consume  = r_key_valid & key_ready;
  assign w_issue    = ((r_state == DEB_PRESS) && w_row_low && w_deb_done) || w_rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows_meta <= 4'hF;
      r_rows_s    <= 4'hF;
    end else begin
      r_rows_meta <= rows;
      r_rows_s    <= r_rows_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SCAN;
      r_col     <= 2'd0;
      r_row     <= 2'd0;
      r_cols    <= 4'b1110;
      r_div_cnt <= 16'd0;
      r_deb_cnt <= 24'd0;
    end else begin
      case (r_state)
        SCAN: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= 16'd0;
            if (w_any_low) begin
              r_row     <= w_low_row;
              r_deb_cnt <= 24'd0;
              r_state   <= DEB_PRESS;
            end else begin
              r_col  <= w_next_col;
              r_cols <= ~(4'b0001 << w_next_col);
            end
          end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
          end
        end
        DEB_PRESS: begin
          if (w_row_low) begin
            if (w_deb_done) begin
              r_state   <= HELD;
              r_deb_cnt <= 24'd0;
            end else begin
              r_deb_cnt <= r_deb_cnt + 24'd1;
            end
          end else begin
            r_state   <= SCAN;
            r_col     <= w_next_col;
            r_cols    <= ~(4'b0001 << w_next_col);
            r_div_cnt <= 16'd0;
            r_deb_cnt <= 24'd0;
          end
        end
        HELD: begin
          if (!w_row_low) begin
            r_state   <= DEB_RELEASE;
            r_deb_cnt <= 24'd0;
          end
        end
        DEB_RELEASE: begin
          if (!w_row_low) begin
            if (w_deb_done) begin
              r_state   <= SCAN;
              r_col     <= w_next_col;
              r_cols    <= ~(4'b0001 << w_next_col);
              r_div_cnt <= 16'd0;
              r_deb_cnt <= 24'd0;
            end else begin
              r_deb_cnt <= r_deb_cnt + 24'd1;
            end
          end else begin
            r_state   <= HELD;
            r_deb_cnt <= 24'd0;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [31:0] REP_LAST = 32'(REPEAT_CYCLES - 1);
  logic [31:0] r_rep_cnt;

  // Restarted during every press debounce so the first repeat lands one full interval after the initial code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= 32'd0;
    end else if (r_state == DEB_PRESS) begin
      r_rep_cnt <= 32'd0;
    end else if ((r_state == HELD) && w_row_low) begin
      r_rep_cnt <= (r_rep_cnt == REP_LAST) ? 32'd0 : r_rep_cnt + 32'd1;
    end
  end

  assign w_rep_fire = (r_state == HELD) && w_row_low && (r_rep_cnt == REP_LAST);
`else
  assign w_rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_issue) begin
        if (!r_key_valid || w_consume) begin
          r_key_code  <= {r_row, r_col};
          r_key_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_consume) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign cols      = r_cols;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE=8, REPEAT=20).
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overrun;

  logic       key_down;
  logic [1:0] key_r;
  logic [1:0] key_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A pressed key shorts its row low only while its column is driven low.
  always_comb begin
    rows = 4'hF;
    if (key_down && !cols[key_c]) rows[key_r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rows(rows),
    .cols(cols),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!key_valid && n < limit);
  endtask

  // Returns on the first negedge of a fresh dwell on column c, with the key already down.
  task automatic press_aligned(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] target;
    int guard;
    target = ~(4'b0001 << c);
    guard = 0;
    while (cols === target && guard < 64) begin @(negedge clk); guard++; end
    guard = 0;
    while (cols !== target && guard < 64) begin @(negedge clk); guard++; end
    chk("align_cols", {28'd0, cols}, {28'd0, target});
    key_r    = r;
    key_c    = c;
    key_down = 1'b1;
  endtask

  task automatic watch(input int ncyc, input logic [3:0] exp_code, output int nvalid, output int nover);
    nvalid = 0;
    nover  = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (key_valid) begin
        nvalid++;
        chk("watch_code", {28'd0, key_code}, {28'd0, exp_code});
      end
      if (overrun) nover++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    int m;
    int nv;
    int no;
    logic seen;
    logic [3:0] exp_cols;

    rst_n     = 1'b0;
    key_ready = 1'b1;
    key_down  = 1'b0;
    key_r     = 2'd0;
    key_c     = 2'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cols", {28'd0, cols}, 32'hE);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_code", {28'd0, key_code}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;

    // Idle scan: each column for SCAN_DIV cycles, wrapping back to col 0
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_cols = 4'hF;
      exp_cols[(i / 4) % 4] = 1'b0;
      chk("idle_cols", {28'd0, cols}, {28'd0, exp_cols});
      chk("idle_valid", {31'd0, key_valid}, 32'd0);
    end
    $display("idle scan done cols=%h", cols);

    // Key 6 pressed during col 0: col 2 dwell starts 8 cycles later, +12 to the code
    key_r = 2'd1; key_c = 2'd2; key_down = 1'b1;
    wait_valid(40, n);
    $display("key 6: code=%h after %0d cycles", key_code, n);
    chk("k6_latency", n, 32'd20);
    chk("k6_code", {28'd0, key_code}, 32'h6);
    @(negedge clk);
    chk("k6_valid_one_cycle", {31'd0, key_valid}, 32'd0);
    watch(30, 4'h6, nv, no);
    chk("k6_held_no_repeat_default", nv, 32'd0);
    key_down = 1'b0;
    watch(DEB + 30, 4'h6, nv, no);
    chk("k6_release_no_code", nv, 32'd0);

    // Key F with a single-cycle bounce inside the press debounce
    press_aligned(2'd3, 2'd3);
    n = 0; seen = 1'b0;
    repeat (9) begin @(negedge clk); n++; seen |= key_valid; end
    key_down = 1'b0;
    @(negedge clk); n++; seen |= key_valid;
    key_down = 1'b1;
    wait_valid(60, m);
    n += m;
    $display("key F: code=%h after %0d cycles", key_code, n);
    chk("kf_bounce_no_code", {31'd0, seen}, 32'd0);
    chk("kf_latency", n, 32'd36);
    chk("kf_code", {28'd0, key_code}, 32'hF);
    @(negedge clk);
    chk("kf_valid_one_cycle", {31'd0, key_valid}, 32'd0);
    key_down = 1'b0;
    watch(DEB + 20, 4'hF, nv, no);
    chk("kf_release_no_code", nv, 32'd0);

    // Back-pressure: key 3 waits unconsumed, key 9 is dropped with an overrun
    key_ready = 1'b0;
    press_aligned(2'd0, 2'd3);
    wait_valid(20, n);
    $display("key 3: code=%h after %0d cycles", key_code, n);
    chk("k3_latency", n, 32'd12);
    chk("k3_code", {28'd0, key_code}, 32'h3);
    key_down = 1'b0;
    watch(DEB + 20, 4'h3, nv, no);
    chk("k3_valid_held", nv, DEB + 20);
    press_aligned(2'd2, 2'd1);
    watch(20, 4'h3, nv, no);
    $display("key 9: overrun pulses=%0d code=%h", no, key_code);
    chk("k9_valid_held", nv, 32'd20);
    chk("k9_overrun_once", no, 32'd1);
    key_down = 1'b0;
    watch(DEB + 20, 4'h3, nv, no);
    chk("k9_no_late_overrun", no, 32'd0);
    key_ready = 1'b1;
    @(negedge clk);
    chk("k3_consumed", {31'd0, key_valid}, 32'd0);

    // Consume in the same cycle a new code is issued
    key_ready = 1'b0;
    press_aligned(2'd0, 2'd3);
    wait_valid(20, n);
    chk("k3b_code", {28'd0, key_code}, 32'h3);
    key_down = 1'b0;
    repeat (DEB + 20) @(negedge clk);
    press_aligned(2'd1, 2'd1);
    repeat (11) @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    $display("key 5 simultaneous: valid=%b code=%h overrun=%b", key_valid, key_code, overrun);
    chk("k5_sim_valid", {31'd0, key_valid}, 32'd1);
    chk("k5_sim_code", {28'd0, key_code}, 32'h5);
    chk("k5_sim_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    chk("k5_sim_cleared", {31'd0, key_valid}, 32'd0);
    key_down = 1'b0;
    repeat (DEB + 20) @(negedge clk);

    // Reset in the middle of the key 5 press debounce
    press_aligned(2'd1, 2'd1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cols", {28'd0, cols}, 32'hE);
    chk("midrst_valid", {31'd0, key_valid}, 32'd0);
    chk("midrst_code", {28'd0, key_code}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    key_down = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_restart_col0", {28'd0, cols}, 32'hE);
    watch(40, 4'h0, nv, no);
    chk("midrst_no_code", nv, 32'd0);
    $display("reset mid-debounce: codes after release=%0d", nv);

    // Key A held for 3*REP + DEB cycles after the initial code
    press_aligned(2'd2, 2'd2);
    watch(12 + 3 * REP + DEB, 4'hA, nv, no);
    $display("key A held: codes=%0d", nv);
`ifdef KEYPAD_REPEAT_EN
    chk("ka_repeat_codes", nv, 32'd4);
`else
    chk("ka_single_code", nv, 32'd1);
`endif
    chk("ka_no_overrun", no, 32'd0);
    key_down = 1'b0;
    watch(DEB + 20, 4'hA, nv, no);
    chk("ka_release_no_code", nv, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
